// File: rtl/ppi_pkg.sv
// ppi_pkg: shared FSM state, ACK polarity and default timing for the Port B sink
package ppi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, WAIT_SPACE, ACK_LOW, RELEASE} sink_state_t;
    localparam logic ACK_ASSERT = 1'b0;
    localparam logic ACK_DEASSERT = 1'b1;
    localparam int SETUP_CYC_DEF = 2;
    localparam int ACK_WIDTH_DEF = 3;
endpackage

// File: rtl/ppi_sink_fifo.sv
// ppi_sink_fifo: synchronous FIFO; push at full succeeds only alongside a pop, pop at empty is ignored
module ppi_sink_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fill
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full = fill == (AW+1)'(DEPTH);
    assign empty = fill == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ppi_portb_sink.sv
// ppi_portb_sink: PPI Port B mode-1 consumer with ACK handshake and FIFO; PPI_SINK_PARITY_EN stores even parity per byte
module ppi_portb_sink
    import ppi_pkg::*;
#(
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int ACK_WIDTH = ACK_WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic [7:0]             PB,
    input  logic                   OBF_B,
    output logic                   ACK,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   busy
`ifdef PPI_SINK_PARITY_EN
    ,
    output logic                   out_parity
`endif
);
`ifdef PPI_SINK_PARITY_EN
    localparam int W = 9;
`else
    localparam int W = 8;
`endif
    sink_state_t state;
    logic [2:0] sync;
    logic [3:0] cnt;
    logic obf_s, fall, full, empty, pop, push, last_setup;
    logic [W-1:0] din, dout;
    // sync[1] is obf_s; sync[2] is its previous value for edge detection
    assign obf_s = sync[1];
    assign fall = sync[2] & ~sync[1];
    assign pop = out_ready & ~empty;
    assign last_setup = state == SETUP && cnt == 4'(SETUP_CYC - 1);
    assign push = (last_setup && !full) || (state == WAIT_SPACE && (!full || pop));
    assign out_valid = ~empty;
    assign busy = state != IDLE;
`ifdef PPI_SINK_PARITY_EN
    assign din = {^PB, PB};
    assign {out_parity, out_data} = dout;
`else
    assign din = PB;
    assign out_data = dout;
`endif
    ppi_sink_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
        .clk(clk),
        .rst(RST),
        .push(push),
        .pop(pop),
        .din(din),
        .dout(dout),
        .full(full),
        .empty(empty),
        .fill(fill)
    );
    always_ff @(posedge clk) begin
        if (RST) begin
            sync <= 3'b111;
            state <= IDLE;
            cnt <= '0;
            ACK <= ACK_DEASSERT;
        end else begin
            sync <= {sync[1:0], OBF_B};
            case (state)
                IDLE: if (fall) begin
                    state <= SETUP;
                    cnt <= '0;
                end
                SETUP: if (last_setup) begin
                    cnt <= '0;
                    state <= full ? WAIT_SPACE : ACK_LOW;
                    ACK <= full ? ACK_DEASSERT : ACK_ASSERT;
                end else cnt <= cnt + 4'd1;
                WAIT_SPACE: if (!full || pop) begin
                    state <= ACK_LOW;
                    ACK <= ACK_ASSERT;
                    cnt <= '0;
                end
                ACK_LOW: if (cnt == 4'(ACK_WIDTH - 1)) begin
                    state <= RELEASE;
                    ACK <= ACK_DEASSERT;
                end else cnt <= cnt + 4'd1;
                RELEASE: if (obf_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ppi_portb_sink.sv
// tb_ppi_portb_sink: randomized PPI-side driver with a queue-based scoreboard for ppi_portb_sink
module tb_ppi_portb_sink;
    localparam int SC = 2;
    localparam int AWID = 3;
    localparam int DEPTH = 4;
    logic clk = 0, RST = 1, OBF_B = 1, out_ready = 0;
    logic [7:0] PB = 0;
    logic ACK, out_valid, busy;
    logic [7:0] out_data;
    logic [2:0] fill;
`ifdef PPI_SINK_PARITY_EN
    logic out_parity;
`endif
    int errors = 0, checks = 0;
    int acks = 0, vcnt = 0, ready_mode = 0;
    logic ack_prev = 1, pend = 0;
    logic [7:0] pd;
    logic [7:0] mq[$], got[$], exp_q[$];

    always #5 clk = ~clk;

    ppi_portb_sink #(.SETUP_CYC(SC), .ACK_WIDTH(AWID), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .RST(RST),
        .PB(PB),
        .OBF_B(OBF_B),
        .ACK(ACK),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fill(fill),
        .busy(busy)
`ifdef PPI_SINK_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    // Model: an acknowledged byte is in the FIFO; a valid&ready cycle removes the oldest one
    task automatic tick();
        pend = out_valid === 1'b1 && out_ready && !RST;
        pd = out_data;
        @(posedge clk);
        #1;
        if (RST) mq.delete();
        else begin
            if (pend) begin
                got.push_back(pd);
                exp_q.push_back(mq.size() > 0 ? mq.pop_front() : ~pd);
            end
            if (ack_prev === 1'b1 && ACK === 1'b0) begin
                mq.push_back(PB);
                acks++;
            end
        end
        if (out_valid === 1'b1) vcnt++;
        ack_prev = ACK;
        case (ready_mode)
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic wait_ack(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ACK === 1'b0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_rise(output int w);
        w = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ACK === 1'b1) break;
            w++;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
    endtask

    task automatic send(input logic [7:0] b, output int lat, output int w);
        PB = b;
        OBF_B = 0;
        wait_ack(500, lat);
        w = 0;
        if (lat > 0) wait_rise(w);
        OBF_B = 1;
        wait_idle();
    endtask

    task automatic drain();
        ready_mode = 0;
        out_ready = 1;
        for (int i = 0; i < 40 && out_valid === 1'b1; i++) tick();
    endtask

    task automatic test_reset();
        RST = 1;
        tick();
        tick();
        checks++; if (ACK !== 1'b1) begin errors++; $display("FAIL reset_ack: got %b want 1", ACK); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        RST = 0;
        tick();
    endtask

    task automatic test_single();
        int lat, w;
        got.delete();
        exp_q.delete();
        out_ready = 1;
        vcnt = 0;
        send(8'hBD, lat, w);
        checks++; if (lat != SC + 3) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, SC + 3); end
        checks++; if (w != AWID) begin errors++; $display("FAIL single_ack_width: got %0d want %0d", w, AWID); end
        checks++; if (got.size() != 1 || got[0] !== 8'hBD) begin errors++; $display("FAIL single_data: got %0d bytes first %h want BD", got.size(), got.size() > 0 ? got[0] : 8'h00); end
        checks++; if (vcnt != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d want 1", vcnt); end
        checks++; if (fill !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_empty: fill %0d valid %b want 0 0", fill, out_valid); end
    endtask

    task automatic test_backpressure();
        int lat, w;
        got.delete();
        exp_q.delete();
        out_ready = 0;
        for (int b = 1; b <= 4; b++) begin
            send(8'(b), lat, w);
            checks++; if (lat != SC + 3) begin errors++; $display("FAIL bp_latency_%0d: got %0d want %0d", b, lat, SC + 3); end
        end
        checks++; if (fill !== 3'd4) begin errors++; $display("FAIL bp_fill_full: got %0d want 4", fill); end
        PB = 8'h05;
        OBF_B = 0;
        wait_ack(30, lat);
        checks++; if (lat != -1) begin errors++; $display("FAIL bp_withheld: acked after %0d want none", lat); end
        checks++; if (ACK !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_wait_state: ack %b busy %b want 1 1", ACK, busy); end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL bp_ack_after_pop: got %b want 0", ACK); end
        wait_rise(w);
        checks++; if (w != AWID) begin errors++; $display("FAIL bp_ack_width: got %0d want %0d", w, AWID); end
        OBF_B = 1;
        wait_idle();
        checks++; if (fill !== 3'd4) begin errors++; $display("FAIL bp_fill_after: got %0d want 4", fill); end
        checks++; if (got.size() != 1 || got[0] !== 8'h01) begin errors++; $display("FAIL bp_first_pop: got %0d bytes first %h want 01", got.size(), got.size() > 0 ? got[0] : 8'h00); end
        drain();
        for (int i = 0; i < 5; i++) begin
            checks++; if (got.size() != 5 || got[i] !== 8'(i + 1)) begin errors++; $display("FAIL bp_order_%0d: got %h want %h", i, got.size() > i ? got[i] : 8'h00, 8'(i + 1)); end
        end
    endtask

    task automatic test_ordering();
        int lat, w;
        logic [7:0] sent[$];
        got.delete();
        exp_q.delete();
        out_ready = 0;
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            sent.push_back(8'hA0 + 8'(i));
            send(sent[i], lat, w);
        end
        ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            sent.push_back(8'($urandom));
            send(sent[8 + i], lat, w);
        end
        drain();
        checks++; if (got.size() != sent.size()) begin errors++; $display("FAIL order_count: got %0d want %0d", got.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== sent[i] || exp_q[i] !== sent[i]) begin errors++; $display("FAIL order_%0d: got %h model %h want %h", i, got[i], exp_q[i], sent[i]); end
        end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL order_fill: got %0d want 0", fill); end
    endtask

    task automatic test_reset_mid();
        int lat, w;
        out_ready = 0;
        PB = 8'h55;
        OBF_B = 0;
        wait_ack(50, lat);
        checks++; if (lat != SC + 3) begin errors++; $display("FAIL rmid_latency: got %0d want %0d", lat, SC + 3); end
        tick();
        RST = 1;
        OBF_B = 1;
        tick();
        checks++; if (ACK !== 1'b1 || fill !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_state: ack %b fill %0d valid %b busy %b want 1 0 0 0", ACK, fill, out_valid, busy); end
        RST = 0;
        tick();
        got.delete();
        exp_q.delete();
        out_ready = 1;
        send(8'h3C, lat, w);
        checks++; if (lat != SC + 3 || w != AWID) begin errors++; $display("FAIL rmid_next_timing: lat %0d width %0d want %0d %0d", lat, w, SC + 3, AWID); end
        checks++; if (got.size() != 1 || got[0] !== 8'h3C) begin errors++; $display("FAIL rmid_next_data: got %0d bytes first %h want 3C", got.size(), got.size() > 0 ? got[0] : 8'h00); end
    endtask

    task automatic test_held_low();
        int lat, w;
        got.delete();
        exp_q.delete();
        out_ready = 1;
        acks = 0;
        PB = 8'h77;
        OBF_B = 0;
        wait_ack(50, lat);
        wait_rise(w);
        for (int i = 0; i < 2 * (SC + AWID + 3); i++) tick();
        checks++; if (acks != 1) begin errors++; $display("FAIL held_ack_count: got %0d want 1", acks); end
        checks++; if (busy !== 1'b1 || ACK !== 1'b1) begin errors++; $display("FAIL held_release: busy %b ack %b want 1 1", busy, ACK); end
        OBF_B = 1;
        wait_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle: got %b want 0", busy); end
        checks++; if (acks != 1 || got.size() != 1 || got[0] !== 8'h77) begin errors++; $display("FAIL held_capture: acks %0d bytes %0d want 1 1", acks, got.size()); end
    endtask

`ifdef PPI_SINK_PARITY_EN
    task automatic test_parity();
        int lat, w;
        out_ready = 0;
        send(8'hB9, lat, w);
        checks++; if (out_parity !== 1'b1 || out_data !== 8'hB9) begin errors++; $display("FAIL parity_b9: got %b/%h want 1/B9", out_parity, out_data); end
        out_ready = 1;
        tick();
        out_ready = 0;
        send(8'hBD, lat, w);
        checks++; if (out_parity !== 1'b0 || out_data !== 8'hBD) begin errors++; $display("FAIL parity_bd: got %b/%h want 0/BD", out_parity, out_data); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_ordering();
        test_reset_mid();
        test_held_low();
`ifdef PPI_SINK_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "timeout");
    end
endmodule
